// File: rtl/dmem_arbiter.sv
// Purpose: two-way arbiter sharing one single-port data memory between the core MEM stage and the loader.
// Latency: grant is combinational in the request cycle; read data returns to its owner one cycle after the grant.
// Backpressure: a losing requester sees gnt=0 and must hold its request; the core sees this as core_stall.
//
// Ports:
//   clk, reset_n                      - rising-edge clock, asynchronous active-low reset
//   core_req/we/addr/wdata            - core request (fixed priority)
//   core_gnt/rvalid/rdata/stall       - core grant, read response, pipeline hold
//   ld_req/we/addr/wdata              - loader request (starvation-protected)
//   ld_gnt/rvalid/rdata               - loader grant and read response
//   mem_en/we/addr/wdata, mem_rdata   - single-port memory interface, rdata valid the cycle after a read strobe
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4    // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,

  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    CORE_PRI = 1'b0,
    LD_FORCE = 1'b1
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic       OWNER_CORE = 1'b0;
  localparam logic       OWNER_LD   = 1'b1;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_inc;
  logic        rsp_valid;
  logic        rsp_owner;

  logic        ld_win;
  logic        core_win;
  logic        ld_lost;

  // ---------------------------------------------------------------------------
  // Arbitration. The state register is cleared asynchronously, so during reset
  // these terms naturally follow the core-priority rule.
  // ---------------------------------------------------------------------------
  assign ld_win   = ld_req & ((state == LD_FORCE) | ~core_req);
  assign core_win = core_req & ~ld_win;
  assign ld_lost  = ld_req & ~ld_win;
  assign wait_inc = wait_cnt + 4'd1;

  assign core_gnt   = core_win;
  assign ld_gnt     = ld_win;
  assign core_stall = core_req & ~core_win;

  // ---------------------------------------------------------------------------
  // Memory port mux: idle cycles drive a quiet, all-zero bus.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_win) begin
      mem_en    = 1'b1;
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (core_win) begin
      mem_en    = 1'b1;
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation FSM. The force decision looks at the incremented count so that
  // the loader wins in the cycle right after its MAX_WAIT-th consecutive loss,
  // not one cycle later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CORE_PRI;
      wait_cnt <= '0;
    end else begin
      if (ld_lost) begin
        wait_cnt <= wait_inc;
      end else begin
        wait_cnt <= '0;
      end

      if (state == CORE_PRI) begin
        if (ld_lost && (wait_inc >= MAX_WAIT_C)) begin
          state <= LD_FORCE;
        end
      end else begin
        // One forced grant is enough; a withdrawn loader request also releases the core.
        if (ld_win || !ld_req) begin
          state <= CORE_PRI;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read response tracking: one outstanding read at most, since the memory
  // returns data exactly one cycle after the strobe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_owner <= OWNER_CORE;
    end else begin
      rsp_valid <= (core_win & ~core_we) | (ld_win & ~ld_we);
      rsp_owner <= ld_win ? OWNER_LD : OWNER_CORE;
    end
  end

  // Non-owner read data is forced to zero so neither port sees the other's data.
  assign core_rvalid = rsp_valid & (rsp_owner == OWNER_CORE);
  assign ld_rvalid   = rsp_valid & (rsp_owner == OWNER_LD);
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign ld_rdata    = ld_rvalid   ? mem_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (core port) and a debug/program loader (loader port).
- Core port has fixed priority. A starvation counter forces a loader grant after MAX_WAIT consecutive loader losses.
- Sits between the MEM stage / loader and the data memory array. Routes read data back to the owner with 1-cycle latency and produces the core stall signal consumed by the hazard logic.

Parameters:
- ADDR_W, 10, word address width to memory
- DATA_W, 32, data width
- MAX_WAIT, 4, consecutive lost cycles before loader grant is forced (1..15)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous reset, active low
- core_req  in  1  core access request
- core_we  in  1  core write (1) / read (0)
- core_addr  in  ADDR_W  core word address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core request accepted this cycle
- core_rvalid  out  1  core read data valid
- core_rdata  out  DATA_W  core read data
- core_stall  out  1  core_req & ~core_gnt
- ld_req  in  1  loader access request
- ld_we  in  1  loader write / read
- ld_addr  in  ADDR_W  loader word address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader request accepted this cycle
- ld_rvalid  out  1  loader read data valid
- ld_rdata  out  DATA_W  loader read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe

Behaviour:
- Grants are combinational in the request cycle; at most one grant per cycle. mem_* are driven from the winner; when there is no winner, mem_en = 0 and mem_we = 0.
- Request signals must stay stable while req is high and gnt is low. Requests are never dropped internally.
- FSM states:
  - CORE_PRI (reset state): core wins any simultaneous request; loader wins only when core_req = 0.
  - LD_FORCE: loader wins if ld_req = 1, otherwise core wins.
- wait_cnt (4 bits):
  - Increments when ld_req & ~ld_gnt; clears on ld_gnt or ld_req = 0.
  - When wait_cnt reaches MAX_WAIT, next state is LD_FORCE.
  - LD_FORCE returns to CORE_PRI after one loader grant, or when ld_req drops.
- Read response:
  - Registers rsp_valid and rsp_owner at the edge following a granted read (we = 0).
  - Next cycle: the owner's rvalid = 1 and its rdata = mem_rdata. The other port's rvalid = 0 and its rdata = 0.
  - Writes produce no rvalid. Back-to-back reads give one rvalid per grant, in grant order.
- Latency: grant in cycle N; read data is valid in cycle N+1; a write is committed at the edge ending cycle N.
- Reset (asynchronous, any time including mid-read): state = CORE_PRI, wait_cnt = 0, rsp_valid = 0, rsp_owner = core. All rvalid outputs are 0 and all rdata outputs are 0 immediately.
  - Grant, stall and mem_* outputs stay combinational from the inputs during reset, subject to the priority rule of CORE_PRI.
  - A read in flight at reset is discarded.
- core_stall holds the pipeline while core_req = 1 and the loader is forced.

Test Plan:
- Core read addr 0x010 alone, mem_rdata = 0x0000_0010 → core_gnt = 1 in cycle N; core_rvalid = 1 and core_rdata = 0x10 in N+1; ld_rvalid = 0.
- Core and loader both request continuously, MAX_WAIT = 4 → core granted cycles 0-3; ld_gnt and core_stall = 1 in cycle 4; core granted again from cycle 5.
- Loader write addr 0x3FF, data 0xDEAD_BEEF, core idle → mem_en = 1, mem_we = 1, mem_addr = 0x3FF in the grant cycle; no rvalid on either port.
- Alternating reads: core grant cycle 0, loader grant cycle 1 → core_rvalid in cycle 1, ld_rvalid in cycle 2, each carrying that cycle's mem_rdata.
- Assert reset_n = 0 mid-cycle after a granted core read → core_rvalid drops to 0 asynchronously. After release: state CORE_PRI, wait_cnt = 0, no stale rvalid.
- ld_req drops while in LD_FORCE with core_req = 1 → core granted the same cycle; FSM returns to CORE_PRI and wait_cnt = 0.
